// File: rtl/spi_pkg.sv
// Shared types and mode constants for the SPI master transfer engine.
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        XFER,
        TRAIL,
        DONE
    } spi_state_t;

    // CPHA values: which sclk edge of each bit cell samples miso
    localparam int unsigned SAMPLE_LEADING  = 0;
    localparam int unsigned SAMPLE_TRAILING = 1;

endpackage

// File: rtl/spi_clk_gen.sv
// sclk divider: counts CLK_DIV dclk cycles per half-period while enabled and
// toggles sclk at each half-period end when toggling is allowed.
module spi_clk_gen #(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CPOL    = 0
) (
    input  logic dclk,
    input  logic rst_n,
    input  logic en,
    input  logic sclk_en,
    output logic div_stb,
    output logic lead_stb,
    output logic trail_stb,
    output logic sclk
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic IDLE_LVL = CPOL[0];

    logic [DIV_W-1:0] div_cnt;
    logic             sclk_q;

    assign div_stb   = en && (div_cnt == DIV_LAST);
    assign lead_stb  = div_stb && sclk_en && (sclk_q == IDLE_LVL);
    assign trail_stb = div_stb && sclk_en && (sclk_q != IDLE_LVL);
    assign sclk      = sclk_q;

    // Disabling parks the divider at zero and sclk at its idle level
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            sclk_q  <= IDLE_LVL;
        end else if (!en) begin
            div_cnt <= '0;
            sclk_q  <= IDLE_LVL;
        end else begin
            div_cnt <= div_stb ? '0 : div_cnt + 1'b1;
            if (div_stb && sclk_en) begin
                sclk_q <= ~sclk_q;
            end
        end
    end

endmodule

// File: rtl/spi_master_xfer.sv
// SPI master transfer engine: frames one DATA_W word per start with cs_n,
// full-duplex shift in all four CPOL/CPHA modes, start/busy/done handshake.
module spi_master_xfer
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned CPOL    = 0,
    parameter int unsigned CPHA    = 0
) (
    input  logic              dclk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              lsb_first,
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int unsigned EDGE_W = $clog2(2 * DATA_W);
    localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    spi_state_t state_q, state_d;

    logic [DATA_W-1:0] tx_sr, rx_sr, tx_rev, rx_rev;
    logic [EDGE_W-1:0] edge_cnt;
    logic              lsb_q, mosi_q;
    logic              div_stb, lead_stb, trail_stb;
    logic              sample_stb, shift_stb, active;

    assign active = (state_q == LEAD) || (state_q == XFER) || (state_q == TRAIL);

    spi_clk_gen #(
        .CLK_DIV (CLK_DIV),
        .CPOL    (CPOL)
    ) u_clk_gen (
        .dclk      (dclk),
        .rst_n     (rst_n),
        .en        (active),
        .sclk_en   (state_q == XFER),
        .div_stb   (div_stb),
        .lead_stb  (lead_stb),
        .trail_stb (trail_stb),
        .sclk      (sclk)
    );

    // The last trailing edge in CPHA=0 must not shift, so mosi holds the final bit
    assign sample_stb = (CPHA == SAMPLE_LEADING) ? lead_stb : trail_stb;
    assign shift_stb  = (CPHA == SAMPLE_LEADING) ? (trail_stb && (edge_cnt != EDGE_LAST))
                                                 : lead_stb;

    always_comb begin
        tx_rev = '0;
        rx_rev = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            tx_rev[i] = tx_data[DATA_W-1-i];
            rx_rev[i] = rx_sr[DATA_W-1-i];
        end
    end

    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LEAD;
            LEAD:    if (div_stb) state_d = XFER;
            XFER:    if (div_stb && (edge_cnt == EDGE_LAST)) state_d = TRAIL;
            TRAIL:   if (div_stb) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
        cs_n = (state_q == IDLE) || (state_q == DONE);
        mosi = 1'b0;
        if (active) begin
            mosi = (CPHA == SAMPLE_LEADING) ? tx_sr[DATA_W-1] : mosi_q;
        end
    end

    // LSB-first words are reversed on the way in and out so the shifters always run MSB-first
    always_ff @(posedge dclk or negedge rst_n) begin
        if (!rst_n) begin
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            edge_cnt <= '0;
            lsb_q    <= 1'b0;
            mosi_q   <= 1'b0;
        end else begin
            if ((state_q == IDLE) && start) begin
                tx_sr    <= lsb_first ? tx_rev : tx_data;
                lsb_q    <= lsb_first;
                rx_sr    <= '0;
                edge_cnt <= '0;
                mosi_q   <= 1'b0;
            end
            if ((state_q == XFER) && div_stb) begin
                edge_cnt <= edge_cnt + 1'b1;
            end
            if (sample_stb) begin
                rx_sr <= {rx_sr[DATA_W-2:0], miso};
            end
            if (shift_stb) begin
                mosi_q <= tx_sr[DATA_W-1];
                tx_sr  <= {tx_sr[DATA_W-2:0], 1'b0};
            end
            if ((state_q == TRAIL) && div_stb) begin
                rx_data <= lsb_q ? rx_rev : rx_sr;
            end
        end
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// Bench for spi_master_xfer: four 16-bit instances (modes 0-3, CLK_DIV=2) and one
// 8-bit CLK_DIV=1 mode-0 instance, each driven against a protocol-level SPI slave.
module tb_spi_master_xfer;

    logic       dclk  = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] start_v = '0;
    logic [4:0] lsb_v   = '0;
    logic [4:0] miso_v  = '0;
    logic [15:0] tx_v [5] = '{default: 16'h0};
    wire  [4:0] busy_v, done_v, sclk_v, mosi_v, csn_v;
    wire  [15:0] rx_v [4];
    wire  [7:0]  rx8;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 dclk = ~dclk;
    always @(posedge dclk) cyc++;

    for (genvar g = 0; g < 4; g++) begin : g_mode
        spi_master_xfer #(
            .DATA_W  (16),
            .CLK_DIV (2),
            .CPOL    (g / 2),
            .CPHA    (g % 2)
        ) u_dut (
            .dclk      (dclk),
            .rst_n     (rst_n),
            .start     (start_v[g]),
            .lsb_first (lsb_v[g]),
            .tx_data   (tx_v[g]),
            .busy      (busy_v[g]),
            .done      (done_v[g]),
            .rx_data   (rx_v[g]),
            .sclk      (sclk_v[g]),
            .mosi      (mosi_v[g]),
            .miso      (miso_v[g]),
            .cs_n      (csn_v[g])
        );
    end

    spi_master_xfer #(
        .DATA_W  (8),
        .CLK_DIV (1),
        .CPOL    (0),
        .CPHA    (0)
    ) u_dut8 (
        .dclk      (dclk),
        .rst_n     (rst_n),
        .start     (start_v[4]),
        .lsb_first (lsb_v[4]),
        .tx_data   (tx_v[4][7:0]),
        .busy      (busy_v[4]),
        .done      (done_v[4]),
        .rx_data   (rx8),
        .sclk      (sclk_v[4]),
        .mosi      (mosi_v[4]),
        .miso      (miso_v[4]),
        .cs_n      (csn_v[4])
    );

    function automatic int w_of(input int i);    return (i == 4) ? 8 : 16;      endfunction
    function automatic int cd_of(input int i);   return (i == 4) ? 1 : 2;       endfunction
    function automatic int pol_of(input int i);  return (i == 4) ? 0 : i / 2;   endfunction
    function automatic int pha_of(input int i);  return (i == 4) ? 0 : i % 2;   endfunction
    function automatic logic [15:0] mask_of(input int i);
        return (i == 4) ? 16'h00FF : 16'hFFFF;
    endfunction
    function automatic logic [15:0] rx_of(input int i);
        return (i == 4) ? {8'h00, rx8} : rx_v[i];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Protocol-level slave: reacts to sclk edges as the SPI mode defines them
    logic [15:0] s_word [5] = '{default: 16'h0};
    logic [4:0]  s_lsb  = '0;
    logic [4:0]  lb     = '0;
    logic [15:0] s_rx [5]    = '{default: 16'h0};
    logic [15:0] last_rx [5] = '{default: 16'h0};
    int s_ns [5]        = '{default: 0};
    int s_edges [5]     = '{default: 0};
    int s_ones [5]      = '{default: 0};
    int s_first [5]     = '{default: 0};
    int s_last_lead [5] = '{default: -1};
    int last_edges [5]  = '{default: 0};
    int last_ones [5]   = '{default: 0};
    int last_first [5]  = '{default: 0};
    int frames [5]      = '{default: 0};
    int frame_err [5]   = '{default: 0};
    int idle_err [5]    = '{default: 0};
    int gap_min [5]     = '{default: 1000};
    int gap_max [5]     = '{default: 0};
    logic [4:0] prev_cs   = '1;
    logic [4:0] prev_sclk = '0;

    function automatic int pos_of(input int i, input int n);
        return s_lsb[i] ? n : w_of(i) - 1 - n;
    endfunction

    always @(negedge dclk) begin
        for (int i = 0; i < 5; i++) begin
            if (csn_v[i] && ((sclk_v[i] != pol_of(i)) || mosi_v[i])) idle_err[i]++;
            if (prev_cs[i] && !csn_v[i]) begin
                s_ns[i] = 0; s_edges[i] = 0; s_ones[i] = 0; s_first[i] = 0;
                s_rx[i] = '0; s_last_lead[i] = -1;
                if (pha_of(i) == 0) begin
                    if (!lb[i]) miso_v[i] = s_word[i][pos_of(i, 0)];
                    s_ns[i] = 1;
                end
            end else if (!csn_v[i] && (sclk_v[i] != prev_sclk[i])) begin
                bit lead;
                lead = (prev_sclk[i] == pol_of(i));
                if (lead) begin
                    if (s_last_lead[i] >= 0) begin
                        if (cyc - s_last_lead[i] < gap_min[i]) gap_min[i] = cyc - s_last_lead[i];
                        if (cyc - s_last_lead[i] > gap_max[i]) gap_max[i] = cyc - s_last_lead[i];
                    end
                    s_last_lead[i] = cyc;
                end
                if (lead == (pha_of(i) == 0)) begin
                    if (s_edges[i] < w_of(i)) s_rx[i][pos_of(i, s_edges[i])] = mosi_v[i];
                    if (s_edges[i] == 0) s_first[i] = int'(mosi_v[i]);
                    s_ones[i] += int'(mosi_v[i]);
                    s_edges[i]++;
                end else if (s_ns[i] < w_of(i)) begin
                    if (!lb[i]) miso_v[i] = s_word[i][pos_of(i, s_ns[i])];
                    s_ns[i]++;
                end
            end
            if (!prev_cs[i] && csn_v[i] && rst_n) begin
                frames[i]++;
                if (s_edges[i] != w_of(i)) frame_err[i]++;
                last_rx[i] = s_rx[i]; last_edges[i] = s_edges[i];
                last_ones[i] = s_ones[i]; last_first[i] = s_first[i];
            end
            if (lb[i]) miso_v[i] = mosi_v[i];
            prev_cs[i]   = csn_v[i];
            prev_sclk[i] = sclk_v[i];
        end
    end

    // One word on instance i; expectations come from the mode/width rules only
    task automatic xfer(input int i, input logic [15:0] tx, input bit lsb,
                        input logic [15:0] sw, input bit loop);
        int lat = (2 * w_of(i) + 2) * cd_of(i);
        int done_at = -1, ndone = 0, busy_err = 0;
        logic [15:0] exp_rx = loop ? (tx & mask_of(i)) : (sw & mask_of(i));
        @(negedge dclk);
        lb[i] = loop; s_word[i] = sw & mask_of(i); s_lsb[i] = lsb;
        tx_v[i] = tx; lsb_v[i] = lsb; start_v[i] = 1'b1;
        @(negedge dclk);
        start_v[i] = 1'b0; tx_v[i] = 16'($urandom); lsb_v[i] = ~lsb;
        for (int m = 0; m <= lat + 4; m++) begin
            if (m > 0) @(negedge dclk);
            if (busy_v[i] != (m <= lat)) busy_err++;
            if (done_v[i]) begin ndone++; done_at = m; end
        end
        check_eq($sformatf("done_lat%0d", i), done_at, lat);
        check_eq($sformatf("done_cnt%0d", i), ndone, 1);
        check_eq($sformatf("busy_win%0d", i), busy_err, 0);
        check_eq($sformatf("rx_data%0d", i), rx_of(i), exp_rx);
        check_eq($sformatf("slave_rx%0d", i), last_rx[i], tx & mask_of(i));
        check_eq($sformatf("slave_edges%0d", i), last_edges[i], w_of(i));
    endtask

    initial begin
        logic [4:0] idle_exp;
        int nd, lat, words, low_len, high_len, len_err, gap_bad, seen_rise;
        logic [15:0] storm_tx;

        repeat (3) @(negedge dclk);
        idle_exp = '0;
        for (int i = 0; i < 5; i++) idle_exp[i] = 1'(pol_of(i));
        check_eq("rst_cs_n", csn_v, 5'h1F);
        check_eq("rst_busy", busy_v, 5'h00);
        check_eq("rst_done", done_v, 5'h00);
        check_eq("rst_mosi", mosi_v, 5'h00);
        check_eq("rst_sclk", sclk_v, idle_exp);
        check_eq("rst_rx", rx_of(0) | rx_of(1) | rx_of(2) | rx_of(3) | rx_of(4), 0);
        rst_n = 1'b1;

        xfer(0, 16'hA5C3, 1'b0, 16'h0000, 1'b1);
        for (int i = 1; i < 4; i++) xfer(i, 16'h0F0F, 1'b0, 16'h3C5A, 1'b0);
        xfer(0, 16'h0001, 1'b1, 16'h8000, 1'b0);
        check_eq("lsb_first_bit", last_first[0], 1);
        check_eq("lsb_ones", last_ones[0], 1);
        xfer(4, 16'h00FF, 1'b0, 16'h0000, 1'b1);

        for (int i = 0; i < 5; i++)
            for (int r = 0; r < 3; r++)
                xfer(i, 16'($urandom), 1'($urandom_range(0, 1)), 16'($urandom),
                     1'($urandom_range(0, 1)));

        // Reset in the middle of XFER half-period 10
        @(negedge dclk);
        tx_v[0] = 16'h1234; lb[0] = 1'b1; start_v[0] = 1'b1;
        @(negedge dclk);
        start_v[0] = 1'b0;
        repeat (22) @(negedge dclk);
        @(posedge dclk);
        #2 rst_n = 1'b0;
        #1;
        check_eq("mid_rst_cs_n", csn_v[0], 1'b1);
        check_eq("mid_rst_sclk", sclk_v[0], 1'b0);
        check_eq("mid_rst_busy", busy_v[0], 1'b0);
        check_eq("mid_rst_rx", rx_of(0), 0);
        nd = 0;
        for (int c = 0; c < 80; c++) begin
            @(negedge dclk);
            if (c == 3) rst_n = 1'b1;
            if (done_v[0]) nd++;
        end
        check_eq("mid_rst_no_done", nd, 0);
        xfer(0, 16'($urandom), 1'b0, 16'($urandom), 1'b0);

        // start held high continuously: count accepts from the frame period alone
        lat = (2 * w_of(0) + 2) * cd_of(0);
        words = 0;
        for (int c = 0; c < 200; c++) if (c % (lat + 2) == 0) words++;
        storm_tx = 16'($urandom);
        lb[0] = 1'b1; lsb_v[0] = 1'b0; tx_v[0] = storm_tx;
        nd = 0; low_len = 0; high_len = 0; len_err = 0; gap_bad = 0; seen_rise = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge dclk);
            if (c > 0) begin
                if (done_v[0]) nd++;
                if (!csn_v[0]) begin
                    if (high_len > 0 && seen_rise != 0 && high_len < 2) gap_bad++;
                    high_len = 0;
                    low_len++;
                end else begin
                    if (low_len > 0) begin
                        if (low_len != lat) len_err++;
                        seen_rise = 1;
                    end
                    low_len = 0;
                    high_len++;
                end
            end
            start_v[0] = (c < 200);
        end
        check_eq("storm_dones", nd, words);
        check_eq("storm_frame_len", len_err, 0);
        check_eq("storm_cs_gap", gap_bad, 0);
        check_eq("storm_rx", rx_of(0), storm_tx);

        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("idle_level%0d", i), idle_err[i], 0);
            check_eq($sformatf("frame_edges%0d", i), frame_err[i], 0);
            check_eq($sformatf("sclk_period_min%0d", i), gap_min[i], 2 * cd_of(i));
            check_eq($sformatf("sclk_period_max%0d", i), gap_max[i], 2 * cd_of(i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
